// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage : single-cycle execute stage.
// A 32-bit ALU (add, sub, three shifts, three bitwise ops) plus a branch
// target adder, with every result captured in output registers. The stage
// supports a stall (i_en=0 holds), a bubble insert (i_flush zeroes the
// registers and clears o_valid) and an asynchronous active-low reset.
// ---------------------------------------------------------------------------
module ex_stage (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_en,
    input  logic        i_flush,
    input  logic [31:0] i_PC,
    input  logic [31:0] i_register1,
    input  logic [31:0] i_register2,
    input  logic [31:0] i_constante,
    input  logic        i_ALUSrc,
    input  logic [2:0]  i_ALUControl,
    output logic [31:0] o_ALUResult,
    output logic [31:0] o_PCBranch,
    output logic        o_zero,
    output logic        o_negative,
    output logic        o_valid
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_AND = 3'b111;

    logic [31:0] operand_a_s;
    logic [31:0] operand_b_s;
    logic [4:0]  shamt_s;
    logic [31:0] result_s;
    logic [31:0] branch_s;
    logic        zero_s;
    logic        negative_s;

    logic [31:0] alu_result_r;
    logic [31:0] pc_branch_r;
    logic        zero_r;
    logic        negative_r;
    logic        valid_r;

    // Operand selection, ALU decode, flag derivation and branch target adder.
    always_comb begin
        operand_a_s = i_register1;
        if (i_ALUSrc) begin
            operand_b_s = i_constante;
        end else begin
            operand_b_s = i_register2;
        end
        // Only the low five bits of B are a meaningful shift distance.
        shamt_s = operand_b_s[4:0];

        case (i_ALUControl)
            OP_ADD:  result_s = operand_a_s + operand_b_s;
            OP_SUB:  result_s = operand_a_s - operand_b_s;
            OP_SLL:  result_s = operand_a_s << shamt_s;
            OP_SRL:  result_s = operand_a_s >> shamt_s;
            OP_SRA:  result_s = $unsigned($signed(operand_a_s) >>> shamt_s);
            OP_XOR:  result_s = operand_a_s ^ operand_b_s;
            OP_OR:   result_s = operand_a_s | operand_b_s;
            OP_AND:  result_s = operand_a_s & operand_b_s;
            default: result_s = 32'd0;
        endcase

        zero_s     = (result_s == 32'd0);
        negative_s = result_s[31];
        // Branch target ignores the operand-B mux and the ALU opcode.
        branch_s   = i_PC + i_constante;
    end

    // Output registers: reset and flush clear everything, stall holds.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            alu_result_r <= 32'd0;
            pc_branch_r  <= 32'd0;
            zero_r       <= 1'b0;
            negative_r   <= 1'b0;
            valid_r      <= 1'b0;
        end else if (i_flush) begin
            alu_result_r <= 32'd0;
            pc_branch_r  <= 32'd0;
            zero_r       <= 1'b0;
            negative_r   <= 1'b0;
            valid_r      <= 1'b0;
        end else if (i_en) begin
            alu_result_r <= result_s;
            pc_branch_r  <= branch_s;
            zero_r       <= zero_s;
            negative_r   <= negative_s;
            valid_r      <= i_valid;
        end else begin
            alu_result_r <= alu_result_r;
            pc_branch_r  <= pc_branch_r;
            zero_r       <= zero_r;
            negative_r   <= negative_r;
            valid_r      <= valid_r;
        end
    end

    assign o_ALUResult = alu_result_r;
    assign o_PCBranch  = pc_branch_r;
    assign o_zero      = zero_r;
    assign o_negative  = negative_r;
    assign o_valid     = valid_r;

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage : scoreboard bench for ex_stage. The driver applies inputs on
// the falling edge and pushes the expected register contents after the next
// rising edge; a monitor pops one entry per rising edge (+1) and compares.
// The reference model computes results from plain arithmetic.
// ---------------------------------------------------------------------------
module tb_ex_stage;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        i_en;
    logic        i_flush;
    logic [31:0] i_PC;
    logic [31:0] i_register1;
    logic [31:0] i_register2;
    logic [31:0] i_constante;
    logic        i_ALUSrc;
    logic [2:0]  i_ALUControl;
    logic [31:0] o_ALUResult;
    logic [31:0] o_PCBranch;
    logic        o_zero;
    logic        o_negative;
    logic        o_valid;

    typedef struct {
        logic [31:0] res;
        logic [31:0] pcb;
        logic        z;
        logic        n;
        logic        v;
        int          id;
    } out_t;

    out_t exp_q[$];
    out_t model_r;
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    ex_stage dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .i_en         (i_en),
        .i_flush      (i_flush),
        .i_PC         (i_PC),
        .i_register1  (i_register1),
        .i_register2  (i_register2),
        .i_constante  (i_constante),
        .i_ALUSrc     (i_ALUSrc),
        .i_ALUControl (i_ALUControl),
        .o_ALUResult  (o_ALUResult),
        .o_PCBranch   (o_PCBranch),
        .o_zero       (o_zero),
        .o_negative   (o_negative),
        .o_valid      (o_valid)
    );

    // Free-running clock, period 10.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference ALU: shifts expressed as multiply/divide by powers of two.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        logic [63:0] pow;
        logic [63:0] wide;
        int          sh;
        sh  = int'(b % 32'd32);
        pow = 64'd1;
        for (int k = 0; k < sh; k++) pow = pow * 64'd2;
        case (op)
            3'd0: ref_alu = a + b;
            3'd1: ref_alu = a + (~b) + 32'd1;
            3'd2: begin wide = {32'd0, a} * pow; ref_alu = wide[31:0]; end
            3'd3: begin wide = {32'd0, a} / pow; ref_alu = wide[31:0]; end
            3'd4: begin
                if (a >= 32'h8000_0000) begin
                    wide = {32'd0, ~a} / pow;
                    ref_alu = ~wide[31:0];
                end else begin
                    wide = {32'd0, a} / pow;
                    ref_alu = wide[31:0];
                end
            end
            3'd5: ref_alu = a ^ b;
            3'd6: ref_alu = a | b;
            default: ref_alu = a & b;
        endcase
    endfunction

    // Drive one cycle of inputs and queue the register contents expected after the next rising edge.
    task automatic step(input logic v, input logic en, input logic fl, input logic src,
                        input logic [2:0] op, input logic [31:0] pc, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] imm);
        logic [31:0] b;
        @(negedge i_clk);
        i_valid = v; i_en = en; i_flush = fl; i_ALUSrc = src; i_ALUControl = op;
        i_PC = pc; i_register1 = r1; i_register2 = r2; i_constante = imm;
        b = src ? imm : r2;
        if (!i_rst_n || fl) begin
            model_r.res = 32'd0; model_r.pcb = 32'd0;
            model_r.z = 1'b0; model_r.n = 1'b0; model_r.v = 1'b0;
        end else if (en) begin
            model_r.res = ref_alu(r1, b, op);
            model_r.pcb = pc + imm;
            model_r.z   = (model_r.res == 32'd0);
            model_r.n   = (model_r.res >= 32'h8000_0000);
            model_r.v   = v;
        end
        step_id++;
        model_r.id = step_id;
        exp_q.push_back(model_r);
    endtask

    // Monitor: compare DUT registers against the oldest expectation after each rising edge.
    always @(posedge i_clk) begin
        out_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("res#%0d", e.id), o_ALUResult, e.res);
            check($sformatf("pcb#%0d", e.id), o_PCBranch, e.pcb);
            check($sformatf("zero#%0d", e.id), {31'd0, o_zero}, {31'd0, e.z});
            check($sformatf("neg#%0d", e.id), {31'd0, o_negative}, {31'd0, e.n});
            check($sformatf("valid#%0d", e.id), {31'd0, o_valid}, {31'd0, e.v});
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_res"}, o_ALUResult, 32'd0);
        check({tag, "_pcb"}, o_PCBranch, 32'd0);
        check({tag, "_zero"}, {31'd0, o_zero}, 32'd0);
        check({tag, "_neg"}, {31'd0, o_negative}, 32'd0);
        check({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
    endtask

    initial begin
        i_rst_n = 1'b1; i_valid = 1'b0; i_en = 1'b0; i_flush = 1'b0; i_ALUSrc = 1'b0;
        i_ALUControl = 3'd0; i_PC = 32'd0; i_register1 = 32'd0; i_register2 = 32'd0;
        i_constante = 32'd0;
        model_r = '{res: 32'd0, pcb: 32'd0, z: 1'b0, n: 1'b0, v: 1'b0, id: 0};

        // Reset applied before any clock edge must clear outputs immediately.
        #1 i_rst_n = 1'b0;
        #1 check_all_zero("reset");
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Basic arithmetic with immediate operand, A=3, imm=2.
        step(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'h0000_0100, 32'd3, 32'd77, 32'd2);
        step(1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 32'h0000_0100, 32'd3, 32'd77, 32'd2);
        step(1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 32'h0000_0100, 32'd3, 32'd77, 32'd2);
        step(1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 32'h0000_0100, 32'd3, 32'd77, 32'd2);
        // Shift distance taken from B[4:0] only.
        step(1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 32'd0, 32'h8000_0000, 32'd0, 32'h8000_0002);
        step(1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 32'd0, 32'h8000_0000, 32'd0, 32'h8000_0002);
        // Logic ops with register operand.
        step(1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 32'd0, 32'hAAAA_AAAA, 32'h5555_5555, 32'd9);
        step(1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 32'd0, 32'h0000_FFFF, 32'hFFFF_0000, 32'd9);
        step(1'b1, 1'b1, 1'b0, 1'b0, 3'd7, 32'd0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'd9);
        // Branch targets, including wrap-around.
        step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_1000, 32'd1, 32'd1, 32'hFFFF_FFF8);
        step(1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 32'hFFFF_FFFC, 32'd1, 32'd1, 32'd8);
        // Stall then flush, starting from result 5 / valid 1.
        step(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'd0, 32'd3, 32'd0, 32'd2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 32'h1234_5678, 32'hDEAD_BEEF, 32'd0, 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 32'h0000_0040, 32'd9, 32'd3, 32'd9);
        step(1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 32'h0000_0040, 32'd3, 32'd3, 32'd2);
        step(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'h0000_0040, 32'd3, 32'd3, 32'd2);

        // Mid-operation async reset: inputs applied, then reset before the edge.
        @(negedge i_clk);
        i_valid = 1'b1; i_en = 1'b1; i_flush = 1'b0; i_ALUSrc = 1'b1; i_ALUControl = 3'd0;
        i_register1 = 32'h8000_0001; i_constante = 32'd7; i_PC = 32'h0000_0200;
        #2 i_rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        model_r.res = 32'd0; model_r.pcb = 32'd0;
        model_r.z = 1'b0; model_r.n = 1'b0; model_r.v = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'h0000_0300, 32'd3, 32'd0, 32'd2);
        step(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'h0000_0300, 32'd3, 32'd0, 32'd2);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'd0, 32'd3, 32'd0, 32'd2);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r1, r2, imm;
            r1  = $urandom;
            r2  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            imm = ($urandom_range(0, 3) == 0) ? 32'(r1) : $urandom;
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)),
                 $urandom, r1, r2, imm);
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge i_clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Ports: one clock; reset is asynchronous and active-low.
REQ-002 i_clk  in  1  rising-edge clock for all output registers.
REQ-003 i_rst_n  in  1  asynchronous active-low reset.
REQ-004 i_valid  in  1  current inputs carry a valid instruction.
REQ-005 i_en  in  1  register load enable; 0 = stall, hold all outputs.
REQ-006 i_flush  in  1  synchronous bubble insert.
REQ-007 i_PC  in  32  PC of the instruction in EX.
REQ-008 i_register1  in  32  rs1 value, ALU operand A.
REQ-009 i_register2  in  32  rs2 value, ALU operand B candidate.
REQ-010 i_constante  in  32  sign-extended immediate.
REQ-011 i_ALUSrc  in  1  operand B select: 0 = i_register2, 1 = i_constante.
REQ-012 i_ALUControl  in  3  ALU operation code.
REQ-013 o_ALUResult  out  32  registered ALU result.
REQ-014 o_PCBranch  out  32  registered branch target.
REQ-015 o_zero  out  1  registered: result equals 0.
REQ-016 o_negative  out  1  registered: result bit 31.
REQ-017 o_valid  out  1  registered copy of i_valid.

Function
REQ-018 B = i_ALUSrc ? i_constante : i_register2; A = i_register1.
REQ-019 i_ALUControl decode, all 32-bit, carries and overflow discarded (mod 2^32):
- 000 ADD: A+B.
- 001 SUB: A-B.
- 010 SLL: A << B[4:0].
- 011 SRL: A >> B[4:0], zero fill.
- 100 SRA: A >>> B[4:0], sign fill.
- 101 XOR.
- 110 OR.
- 111 AND.
REQ-020 Shift amount uses B[4:0] only; B[31:5] is ignored, e.g. B=0x80000002 gives a shift of 2.
REQ-021 Branch target = i_PC + i_constante (mod 2^32), independent of i_ALUSrc and i_ALUControl.
REQ-022 zero = (result == 0); negative = result[31]; both are computed from the same cycle's result.
REQ-023 Latency is 1 cycle: on a rising i_clk with i_en=1 and i_flush=0, all outputs load the combinational values and o_valid loads i_valid.
REQ-024 Outputs are computed regardless of i_valid; o_valid alone marks them meaningful.
REQ-025 i_flush=1 at a rising edge: o_valid<=0 and data and flag outputs <=0; i_flush takes priority over i_en.
REQ-026 i_en=0 and i_flush=0: every output holds its value.
REQ-027 No internal state other than the output registers; there is no state machine.

Reset
REQ-028 i_rst_n=0 immediately, without waiting for a clock, forces o_ALUResult=0, o_PCBranch=0, o_zero=0, o_negative=0 and o_valid=0.
REQ-029 Outputs hold those values while i_rst_n=0.
REQ-030 Normal loading resumes at the first rising edge after i_rst_n deasserts.
REQ-031 Reset asserted mid-operation discards any in-flight result.

Verification
REQ-032 Arithmetic, i_en=1 and i_ALUSrc=1 throughout, A=3, imm=2:
- ADD -> 5, zero=0, neg=0.
- SUB -> 1.
- SLL -> 0x0000000C.
- SRA (100) -> 0, zero=1.
All checked one cycle after inputs apply.
REQ-033 Arithmetic right shift, i_ALUSrc=1: A=0x80000000, imm=0x80000002:
- 100 -> 0xE0000000, neg=1, zero=0.
- 011 -> 0x20000000, neg=0.
REQ-034 Logic ops, i_ALUSrc=0:
- 0xAAAAAAAA XOR 0x55555555 -> 0xFFFFFFFF, neg=1.
- 0x0000FFFF OR 0xFFFF0000 -> 0xFFFFFFFF.
- 0xFFFFFFFF AND 0x0F0F0F0F -> 0x0F0F0F0F, neg=0.
REQ-035 Branch target: PC=0x00001000 with imm=0xFFFFFFF8 -> o_PCBranch=0x00000FF8; PC=0xFFFFFFFC with imm=8 -> 0x00000004 (wraps).
REQ-036 Stall and flush, starting with o_valid=1 and o_ALUResult=5:
- i_en=0 while inputs change -> outputs hold 5 and o_valid=1.
- i_flush=1 together with i_en=1 -> o_valid=0 and o_ALUResult=0 next cycle.
REQ-037 Asynchronous reset: assert i_rst_n=0 between clock edges -> all outputs 0 with no clock edge; deassert and apply ADD 3+2 -> 5 and o_valid=1 one cycle later.
